ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Front end for the 512x8-macro RAM wrapper. Drives its clock-synchronous single-port interface: address, wren, write_data in; read_data one cycle later.
- After reset, clears every word to FILL. Then arbitrates two requesters (port A, port B) onto the single RAM port with round-robin fairness.
- Returns read data with a one-cycle valid strobe.
- Sits between the CPU/PPU bus glue and the RAM wrapper.

Parameters:
- WIDTH, 8: data width in bits.
- WORDS, 2048: RAM depth in words. Must be a multiple of 512.
- FILL, 0: value written to every word during the post-reset clear.
- ADDR_BITS, ceil(log2(WORDS)): localparam. Address width.

Ports:
- clock  in  1  single clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_req  in  1  port A request; held until a_ack
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  ADDR_BITS  port A address
- a_wdata  in  WIDTH  port A write data
- a_ack  out  1  port A grant; combinational, this cycle
- a_rvalid  out  1  port A read data valid
- a_rdata  out  WIDTH  port A read data
- b_req, b_we, b_addr, b_wdata, b_ack, b_rvalid, b_rdata: same as port A, for port B
- mem_address  out  ADDR_BITS  to RAM address
- mem_wren  out  1  to RAM wren
- mem_write_data  out  WIDTH  to RAM write_data
- mem_read_data  in  WIDTH  from RAM read_data; valid one cycle after address
- clear_done  out  1  high once the initial clear has finished

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = CLEAR, clear counter = 0, rr_last = B (so A wins the first tie).
  - a_rvalid, b_rvalid, clear_done = 0.
  - mem_wren forced 0 combinationally while reset_n is low. a_ack, b_ack = 0.
- CLEAR state:
  - Each cycle: mem_address = counter, mem_write_data = FILL, mem_wren = 1. Counter increments.
  - Runs exactly WORDS cycles, covering addresses 0..WORDS-1.
  - After the write to WORDS-1, the next state is RUN and clear_done = 1 on that edge.
  - a_ack and b_ack stay 0 in CLEAR. Requests are held off and are not lost; requesters keep req asserted.
- RUN state, arbitration per cycle (combinational):
  - Only one port requesting: that port is granted.
  - Both requesting: the port not granted last time wins. rr_last updates on every grant.
  - Neither requesting: mem_wren = 0. mem_address holds the last granted address; its value is don't-care but must be stable and X-free.
- Granted cycle:
  - ack = 1. mem_address = port addr, mem_wren = port we, mem_write_data = port wdata.
  - Non-granted ack = 0; that requester holds its inputs.
- Read return:
  - Read granted in cycle N → that port's rvalid = 1 in cycle N+1 only. rdata = mem_read_data in that cycle.
  - a_rdata and b_rdata are both wired to mem_read_data. Only rvalid distinguishes them.
- Writes produce no rvalid. Back-to-back grants are allowed every cycle, so throughput is 1 access per clock.
- Write then read to the same address on consecutive cycles returns the new data. The RAM macro provides this; the arbiter adds no bypass.
- Reset during CLEAR or RUN:
  - Restarts CLEAR from address 0 and drops clear_done.
  - Any pending rvalid is cancelled (forced 0).
- No Verilog X on any output after reset release. All outputs are fully determined by state and inputs.
- Target size: ~150–250 lines.

Test Plan:
- Reset release, WORDS=2048, FILL=8'hA5:
  - mem_wren = 1 for exactly 2048 consecutive cycles, mem_address 0..2047 in order.
  - clear_done rises on the edge after address 2047.
  - A read of addr 1234 then returns 8'hA5 with a_rvalid high one cycle after a_ack.
- a_req held with a read to addr 7 from before reset release:
  - a_ack = 0 throughout CLEAR.
  - a_ack = 1 in the first RUN cycle, then a_rvalid the next cycle.
- Both ports request continuously:
  - A writes addr 10 = 8'h11, B reads addr 10, repeated.
  - Grants alternate A, B, A, B…, with A first.
  - Each B read returns 8'h11 with b_rvalid one cycle after b_ack. a_rvalid is never set.
- Port A back-to-back, one per cycle: write addr 3 = 8'h3C, read addr 3, read addr 4.
  - a_ack high 3 consecutive cycles.
  - a_rvalid high the 2 cycles after the reads, data 8'h3C then FILL.
- Assert reset_n low mid-RUN, one cycle after a B read grant:
  - b_rvalid = 0 immediately; mem_wren = 0 immediately.
  - After release, CLEAR restarts at address 0 and clear_done = 0 until it completes.
- Idle in RUN with no requests for 100 cycles:
  - mem_wren stays 0; no rvalid; RAM contents unchanged (spot-check addresses 0, 511, 512, 2047).

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - Post-reset RAM clear and round-robin two-port arbiter for a single-port RAM
//
// Ports:
//   clock, reset_n                  : single clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata       : port A request, held until a_ack
//   a_ack                           : port A grant, combinational in the granted cycle
//   a_rvalid/a_rdata                : port A read data, one cycle after a read grant
//   b_*                             : same as port A, for port B
//   mem_address/mem_wren/
//   mem_write_data/mem_read_data    : synchronous single-port RAM interface
//   clear_done                      : high once the post-reset clear has finished
module ram_port_arbiter #(
  parameter int unsigned       WIDTH = 8,
  parameter int unsigned       WORDS = 2048,
  parameter logic [WIDTH-1:0]  FILL  = '0,
  localparam int unsigned      ADDR_BITS = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                 clock,
  input  logic                 reset_n,

  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_BITS-1:0] a_addr,
  input  logic [WIDTH-1:0]     a_wdata,
  output logic                 a_ack,
  output logic                 a_rvalid,
  output logic [WIDTH-1:0]     a_rdata,

  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_BITS-1:0] b_addr,
  input  logic [WIDTH-1:0]     b_wdata,
  output logic                 b_ack,
  output logic                 b_rvalid,
  output logic [WIDTH-1:0]     b_rdata,

  output logic [ADDR_BITS-1:0] mem_address,
  output logic                 mem_wren,
  output logic [WIDTH-1:0]     mem_write_data,
  input  logic [WIDTH-1:0]     mem_read_data,

  output logic                 clear_done
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(WORDS - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
  // rr_last_q: 0 = A was granted last, 1 = B was granted last
  logic                   rr_last_q, rr_last_d;
  logic [ADDR_BITS-1:0]   last_addr_q, last_addr_d;
  logic                   a_rvalid_q, a_rvalid_d;
  logic                   b_rvalid_q, b_rvalid_d;
  logic                   clear_done_q, clear_done_d;

  logic                   grant_a, grant_b;
  logic [ADDR_BITS-1:0]   mem_addr_c;
  logic                   mem_wren_c;
  logic [WIDTH-1:0]       mem_wdata_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      rr_last_q    <= 1'b1;
      last_addr_q  <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_last_q    <= rr_last_d;
      last_addr_q  <= last_addr_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_last_d    = rr_last_q;
    last_addr_d  = last_addr_q;
    clear_done_d = clear_done_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    // Idle RUN cycles park the RAM port on the last granted address
    mem_addr_c   = last_addr_q;
    mem_wren_c   = 1'b0;
    mem_wdata_c  = FILL;

    case (state_q)
      ST_CLEAR: begin
        mem_addr_c  = cnt_q;
        mem_wren_c  = 1'b1;
        mem_wdata_c = FILL;
        cnt_d       = cnt_q + ADDR_BITS'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d      = ST_RUN;
          clear_done_d = 1'b1;
          cnt_d        = '0;
        end
      end

      ST_RUN: begin
        // On a tie the port not granted last time wins
        grant_a = a_req && (!b_req || rr_last_q);
        grant_b = b_req && !grant_a;
        if (grant_a) begin
          mem_addr_c  = a_addr;
          mem_wren_c  = a_we;
          mem_wdata_c = a_wdata;
          last_addr_d = a_addr;
          rr_last_d   = 1'b0;
          a_rvalid_d  = !a_we;
        end else if (grant_b) begin
          mem_addr_c  = b_addr;
          mem_wren_c  = b_we;
          mem_wdata_c = b_wdata;
          last_addr_d = b_addr;
          rr_last_d   = 1'b1;
          b_rvalid_d  = !b_we;
        end
      end

      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign a_ack          = grant_a;
  assign b_ack          = grant_b;
  assign a_rvalid       = a_rvalid_q;
  assign b_rvalid       = b_rvalid_q;
  // Both ports see the RAM output; rvalid alone says whose data it is
  assign a_rdata        = mem_read_data;
  assign b_rdata        = mem_read_data;
  assign mem_address    = mem_addr_c;
  // Reset state is CLEAR, so the write enable must be gated while reset is held
  assign mem_wren       = reset_n & mem_wren_c;
  assign mem_write_data = mem_wdata_c;
  assign clear_done     = clear_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - Scoreboard bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;

  localparam int unsigned      WIDTH = 8;
  localparam int unsigned      WORDS = 2048;
  localparam int unsigned      AW    = 11;
  localparam logic [WIDTH-1:0] FILL  = 8'hA5;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             a_req, a_we, a_ack, a_rvalid;
  logic [AW-1:0]    a_addr;
  logic [WIDTH-1:0] a_wdata, a_rdata;
  logic             b_req, b_we, b_ack, b_rvalid;
  logic [AW-1:0]    b_addr;
  logic [WIDTH-1:0] b_wdata, b_rdata;
  logic [AW-1:0]    mem_address;
  logic             mem_wren;
  logic [WIDTH-1:0] mem_write_data, mem_read_data;
  logic             clear_done;

  always #5 clock = ~clock;

  ram_port_arbiter #(.WIDTH(WIDTH), .WORDS(WORDS), .FILL(FILL)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_address(mem_address), .mem_wren(mem_wren),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .clear_done(clear_done)
  );

  logic [WIDTH-1:0] ram [WORDS];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address] <= mem_write_data;
    mem_read_data <= ram[mem_address];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic a_rd_pend = 1'b0;
  logic b_rd_pend = 1'b0;

  always @(negedge clock) begin
    if (!reset_n) begin
      a_rd_pend <= 1'b0;
      b_rd_pend <= 1'b0;
    end else begin
      check_eq("a_rvalid", a_rvalid, a_rd_pend);
      check_eq("b_rvalid", b_rvalid, b_rd_pend);
      if (a_rvalid === 1'b1) begin
        if (qa.size() == 0) check_eq("a_rvalid_no_exp", qa.size(), 1);
        else check_eq("a_rdata", a_rdata, qa.pop_front());
      end
      if (b_rvalid === 1'b1) begin
        if (qb.size() == 0) check_eq("b_rvalid_no_exp", qb.size(), 1);
        else check_eq("b_rdata", b_rdata, qb.pop_front());
      end
      check_eq("ack_exclusive", a_ack & b_ack, 0);
      a_rd_pend <= a_ack & ~a_we;
      b_rd_pend <= b_ack & ~b_we;
    end
  end

  task automatic check_clear();
    for (int i = 0; i < int'(WORDS); i++) begin
      @(negedge clock);
      check_eq("clr_wren", mem_wren, 1);
      check_eq("clr_addr", mem_address, i);
      check_eq("clr_data", mem_write_data, FILL);
      check_eq("clr_done_low", clear_done, 0);
      check_eq("clr_a_ack", a_ack, 0);
      check_eq("clr_b_ack", b_ack, 0);
    end
    @(negedge clock);
    check_eq("clear_done", clear_done, 1);
  endtask

  task automatic xfer(input bit port_b, input logic we, input logic [AW-1:0] addr,
                      input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] exp,
                      output int waited);
    logic ack;
    if (port_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    waited = 0;
    @(negedge clock);
    ack = port_b ? b_ack : a_ack;
    while (ack !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clock);
      ack = port_b ? b_ack : a_ack;
    end
    check_eq(port_b ? "b_ack" : "a_ack", ack, 1);
    check_eq("grant_addr", mem_address, addr);
    check_eq("grant_wren", mem_wren, we);
    if (we) check_eq("grant_wdata", mem_write_data, wd);
    else if (port_b) qb.push_back(exp);
    else qa.push_back(exp);
    @(posedge clock);
    #1;
    if (port_b) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    reset_n = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 11'd7; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0;    b_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_wren", mem_wren, 0);
    check_eq("rst_a_ack", a_ack, 0);
    check_eq("rst_clear_done", clear_done, 0);
    check_eq("rst_a_rvalid", a_rvalid, 0);
    reset_n = 1'b1;

    // Clear sweep with port A holding a read of address 7 throughout
    check_clear();
    check_eq("first_run_a_ack", a_ack, 1);
    check_eq("first_run_addr", mem_address, 7);
    qa.push_back(FILL);
    @(posedge clock);
    #1;
    a_req = 1'b0;

    xfer(1'b0, 1'b0, 11'd1234, '0, FILL, w);

    // Back-to-back port A accesses, one per cycle
    xfer(1'b0, 1'b1, 11'd3, 8'h3C, '0, w);
    check_eq("b2b_wait_wr3", w, 0);
    xfer(1'b0, 1'b0, 11'd3, '0, 8'h3C, w);
    check_eq("b2b_wait_rd3", w, 0);
    xfer(1'b0, 1'b0, 11'd4, '0, FILL, w);
    check_eq("b2b_wait_rd4", w, 0);

    // Reset one cycle after a B read grant cancels the pending strobe
    xfer(1'b1, 1'b0, 11'd3, '0, 8'h3C, w);
    check_eq("b_rvalid_pre_reset", b_rvalid, 1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_b_rvalid", b_rvalid, 0);
    check_eq("mid_rst_wren", mem_wren, 0);
    check_eq("mid_rst_clear_done", clear_done, 0);
    check_eq("mid_rst_b_ack", b_ack, 0);
    qb.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check_clear();

    // Both ports contend: A writes 10, B reads 10; grants alternate starting with A
    @(posedge clock);
    #1;
    a_req = 1'b1; a_we = 1'b1; a_addr = 11'd10; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 11'd10;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check_eq("alt_a_ack", a_ack, (k % 2 == 0) ? 1 : 0);
      check_eq("alt_b_ack", b_ack, (k % 2 == 1) ? 1 : 0);
      if (b_ack === 1'b1) qb.push_back(8'h11);
    end
    @(posedge clock);
    #1;
    a_req = 1'b0; b_req = 1'b0;

    xfer(1'b0, 1'b1, 11'd511, 8'h5A, '0, w);

    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      check_eq("idle_wren", mem_wren, 0);
      check_eq("idle_addr", mem_address, 511);
      check_eq("idle_a_ack", a_ack, 0);
      check_eq("idle_b_ack", b_ack, 0);
    end
    @(posedge clock);
    #1;

    xfer(1'b0, 1'b0, 11'd0,    '0, FILL,  w);
    xfer(1'b0, 1'b0, 11'd511,  '0, 8'h5A, w);
    xfer(1'b1, 1'b0, 11'd512,  '0, FILL,  w);
    xfer(1'b0, 1'b0, 11'd2047, '0, FILL,  w);
    xfer(1'b1, 1'b0, 11'd10,   '0, 8'h11, w);
    xfer(1'b0, 1'b0, 11'd3,    '0, FILL,  w);

    repeat (3) @(negedge clock);
    check_eq("qa_drained", qa.size(), 0);
    check_eq("qb_drained", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
